bwt_mtf_encoder: RTL and testbench

- Move-to-front (MTF) encoder that sits directly downstream of BWT_transform.
- Consumes one 32-bit BWT output word, treated as 8 nibble symbols, when BWT_transform pulses done.
- Emits a 32-bit word of MTF indices for the next compression stage (run-length / entropy coder).
- Each word is encoded independently: the MTF table is re-initialised for every word.

---
 rtl/bwt_pkg.sv | 29 ++
 rtl/mtf_lookup.sv | 34 +++
 rtl/bwt_mtf_encoder.sv | 88 ++++++++
 tb/tb_bwt_mtf_encoder.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bwt_pkg.sv
// Shared types and constants for the BWT move-to-front encoder.
// Symbol 0 of a word is the most significant nibble and is encoded first.
package bwt_pkg;

  localparam int SYM_W  = 4;
  localparam int N_SYM  = 8;
  localparam int ALPHA  = 1 << SYM_W;
  localparam int WORD_W = N_SYM * SYM_W;
  localparam int CNT_W  = $clog2(N_SYM);

  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [0:WORD_W-1] word_t;
  typedef sym_t              mtf_table_t [ALPHA];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mtf_state_e;

  function automatic mtf_table_t identity_table();
    mtf_table_t t;
    for (int i = 0; i < ALPHA; i++) begin
      t[i] = sym_t'(i);
    end
    return t;
  endfunction

endpackage

// File: rtl/mtf_lookup.sv
// Combinational MTF step: finds the position of a symbol in the table and
// builds the table with that symbol moved to the front.
module mtf_lookup
  import bwt_pkg::*;
(
  input  mtf_table_t cur_tbl,
  input  sym_t       sym,
  output sym_t       idx,
  output mtf_table_t next_tbl
);

  // The table is always a permutation of the alphabet, so exactly one entry hits.
  always_comb begin
    idx = '0;
    for (int i = 0; i < ALPHA; i++) begin
      if (cur_tbl[i] == sym) begin
        idx = sym_t'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ALPHA; i++) begin
      next_tbl[i] = cur_tbl[i];
    end
    next_tbl[0] = sym;
    for (int i = 1; i < ALPHA; i++) begin
      if (i <= int'(idx)) begin
        next_tbl[i] = cur_tbl[i-1];
      end
    end
  end

endmodule

// File: rtl/bwt_mtf_encoder.sv
// Move-to-front encoder for one 32-bit BWT word: eight nibbles, one per cycle,
// with the MTF table restarted from identity for every word.
module bwt_mtf_encoder
  import bwt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [0:WORD_W-1] data_in,
  output logic              busy,
  output logic              done,
  output logic [0:WORD_W-1] data_out
);

  mtf_state_e       state;
  mtf_state_e       state_nx;
  word_t            in_sr;
  word_t            out_sr;
  mtf_table_t       tbl;
  mtf_table_t       tbl_nx;
  sym_t             idx;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_sym;

  assign accept   = (state == IDLE) && start;
  assign last_sym = (cnt == CNT_W'(N_SYM - 1));

  mtf_lookup u_lookup (
    .cur_tbl  (tbl),
    .sym      (in_sr[0:SYM_W-1]),
    .idx      (idx),
    .next_tbl (tbl_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_sym) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control, table and result register: all cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      cnt      <= '0;
      tbl      <= identity_table();
    end else begin
      busy <= (state_nx == RUN) || (state_nx == DONE);
      done <= (state == DONE);
      if (state == DONE) begin
        data_out <= out_sr;
      end
      if (accept) begin
        cnt <= '0;
        tbl <= identity_table();
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        tbl <= tbl_nx;
      end
    end
  end

  // Symbol shift registers: contents are only meaningful while in RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      in_sr <= data_in;
    end else if (state == RUN) begin
      in_sr  <= {in_sr[SYM_W:WORD_W-1], sym_t'(0)};
      out_sr <= {out_sr[SYM_W:WORD_W-1], idx};
    end
  end

endmodule

// File: tb/tb_bwt_mtf_encoder.sv
// Scoreboard bench for bwt_mtf_encoder: expected MTF words and done cycles are
// queued at start and compared whenever done is seen.
module tb_bwt_mtf_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] din = '0;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int dones = 0;

  logic [31:0] sb_exp[$];
  int          sb_cyc[$];

  bwt_mtf_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (din),
    .busy     (busy),
    .done     (done),
    .data_out (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mtf_model(input logic [31:0] w);
    int          t[16];
    int          s;
    int          j;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) t[i] = i;
    for (int k = 0; k < 8; k++) begin
      s = int'(w[31-4*k -: 4]);
      j = 0;
      while (t[j] != s) j++;
      r[31-4*k -: 4] = 4'(j);
      for (int m = j; m > 0; m--) t[m] = t[m-1];
      t[0] = s;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      dones++;
      if (sb_exp.size() == 0) begin
        check_eq("spurious_done", {31'b0, done}, 32'h0);
      end else begin
        check_eq("data_out", dout, sb_exp.pop_front());
        check_eq("latency", cyc, sb_cyc.pop_front());
      end
    end
  end

  // glitch_at >= 0 re-pulses start with other data that many cycles into RUN.
  task automatic send_wait(input logic [31:0] w, input bit chk_busy, input int glitch_at);
    int nb;
    bit got;
    nb = 0;
    got = 0;
    @(negedge clk);
    start = 1'b1;
    din = w;
    sb_exp.push_back(mtf_model(w));
    sb_cyc.push_back(cyc + 10);
    starts++;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      start = (i == glitch_at);
      din = $urandom;
      if (busy) nb++;
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) check_eq("done_timeout", 32'h0, 32'h1);
    if (chk_busy) check_eq("busy_cycles", nb, 9);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("reset_busy", {31'b0, busy}, 32'h0);
    check_eq("reset_done", {31'b0, done}, 32'h0);
    check_eq("reset_dout", dout, 32'h0);

    send_wait(32'h0AB2C1AF, 1, -1);
    check_eq("vector_0AB2C1AF", dout, 32'h0AB4C54F);
    send_wait(32'h11111111, 1, -1);
    check_eq("vector_11111111", dout, 32'h10000000);
    send_wait(32'hFFFFFFFF, 0, -1);
    check_eq("vector_FFFFFFFF", dout, 32'hF0000000);
    send_wait(32'h01234567, 0, -1);
    check_eq("vector_01234567", dout, 32'h01234567);
    send_wait(32'h00000000, 0, -1);
    check_eq("vector_00000000", dout, 32'h00000000);

    send_wait(32'h0AB2C1AF, 1, 3);
    repeat (12) @(negedge clk);
    check_eq("hold_after_idle", dout, 32'h0AB4C54F);

    // Abort a word with an asynchronous reset between clock edges.
    @(negedge clk);
    start = 1'b1;
    din = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("async_busy", {31'b0, busy}, 32'h0);
    check_eq("async_done", {31'b0, done}, 32'h0);
    check_eq("async_dout", dout, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    send_wait(32'h0AB2C1AF, 1, -1);
    check_eq("after_reset", dout, 32'h0AB4C54F);

    for (int n = 0; n < 200; n++) begin
      send_wait($urandom, 0, -1);
    end
    repeat (12) @(negedge clk);
    check_eq("done_count", dones, starts);
    check_eq("sb_empty", sb_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
